rand_request_arbiter: RTL

// Shares the keyboard-latched random generator among N_REQ requesters (spawners, asteroid placer, etc.).

---
 rtl/rand_arb_pkg.sv | 7 +
 rtl/rand_request_arbiter_if.sv | 24 ++
 rtl/rr_arbiter.sv | 22 ++
 rtl/rand_request_arbiter.sv | 92 +++++++++
 4 files changed

// File: rtl/rand_arb_pkg.sv
// rand_arb_pkg: shared FSM state type and width helper for the random request arbiter.
package rand_arb_pkg;
  typedef enum logic [1:0] {IDLE, FIRE, SETTLE, DONE} rand_arb_state_t;
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rand_request_arbiter_if.sv
// rand_request_arbiter_if: requester bus plus generator handshake of the random request arbiter.
interface rand_request_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int SIZE_BITS = 8
) ();
  localparam int ID_W = rand_arb_pkg::id_w(N_REQ);
  logic [N_REQ-1:0] req;
  logic [N_REQ*SIZE_BITS-1:0] req_limit;
  logic rnd_rise;
  logic [SIZE_BITS-1:0] rnd_dout;
  logic valid;
  logic [ID_W-1:0] id;
  logic [SIZE_BITS-1:0] value;
  logic busy;
  logic exhausted;
  modport slave (
    input req, req_limit, rnd_dout,
    output rnd_rise, valid, id, value, busy, exhausted
  );
  modport master (
    output req, req_limit, rnd_dout,
    input rnd_rise, valid, id, value, busy, exhausted
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from last_id+1 upward with wrap.
module rr_arbiter import rand_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int ID_W = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic             gnt_any,
  output logic [ID_W-1:0]  gnt_id
);
  logic [ID_W-1:0] k;
  assign gnt_any = |req;
  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_id = '0;
    k = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      k = ID_W'((int'(last_id) + i) % N_REQ);
      if (req[k]) gnt_id = k;
    end
  end
endmodule

// File: rtl/rand_request_arbiter.sv
// rand_request_arbiter: shares one latched random generator among requesters,
// range-limiting each sample by rejection with a bounded retry fallback to 0.
module rand_request_arbiter import rand_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int SIZE_BITS = 8,
  parameter int MAX_RETRY = 7
) (
  input logic clk,
  input logic resetN,
  rand_request_arbiter_if.slave bus
);
  localparam int ID_W = id_w(N_REQ);
  localparam int RW = id_w(MAX_RETRY + 1);
  rand_arb_state_t state_q, state_d;
  logic [ID_W-1:0] win_id_q, win_id_d, last_id_q, last_id_d, gnt_id;
  logic [SIZE_BITS-1:0] limit_q, limit_d, value_q, value_d;
  logic [RW-1:0] retry_q, retry_d;
  logic exh_q, exh_d, gnt_any;
  logic [SIZE_BITS-1:0] lim [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_lim
    assign lim[g] = bus.req_limit[g*SIZE_BITS +: SIZE_BITS];
  end
  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req(bus.req),
    .last_id(last_id_q),
    .gnt_any(gnt_any),
    .gnt_id(gnt_id)
  );
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      win_id_q <= '0;
      last_id_q <= '0;
      limit_q <= '0;
      value_q <= '0;
      retry_q <= '0;
      exh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_id_q <= win_id_d;
      last_id_q <= last_id_d;
      limit_q <= limit_d;
      value_q <= value_d;
      retry_q <= retry_d;
      exh_q <= exh_d;
    end
  end
  always_comb begin
    state_d = state_q;
    win_id_d = win_id_q;
    last_id_d = last_id_q;
    limit_d = limit_q;
    value_d = value_q;
    retry_d = retry_q;
    exh_d = exh_q;
    case (state_q)
      IDLE: if (gnt_any) begin
        win_id_d = gnt_id;
        limit_d = lim[gnt_id];
        retry_d = '0;
        exh_d = 1'b0;
        state_d = FIRE;
      end
      FIRE: state_d = SETTLE;
      SETTLE: begin
        // Requester withdrew: drop the sample without touching fairness state.
        if (!bus.req[win_id_q]) state_d = IDLE;
        else if (limit_q == '0 || bus.rnd_dout < limit_q) begin
          value_d = bus.rnd_dout;
          state_d = DONE;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = FIRE;
        end else begin
          value_d = '0;
          exh_d = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        last_id_d = win_id_q;
        state_d = IDLE;
      end
    endcase
  end
  assign bus.rnd_rise = state_q == FIRE;
  assign bus.valid = state_q == DONE;
  assign bus.id = win_id_q;
  assign bus.value = value_q;
  assign bus.busy = state_q != IDLE;
  assign bus.exhausted = (state_q == DONE) && exh_q;
endmodule
